// File: rtl/spraid_host_queue_if.sv
// rtl/spraid_host_queue_if.sv - host command/response and RAID host-port signal bundle
interface spraid_host_queue_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        raid_read;
    logic        raid_write;
    logic [31:0] raid_addr;
    logic [31:0] raid_din;
    logic [31:0] raid_dout;
    logic        raid_busy;
    logic        raid_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, raid_dout, raid_busy, raid_err,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, raid_read, raid_write, raid_addr, raid_din
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, raid_dout, raid_busy, raid_err,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, raid_read, raid_write, raid_addr, raid_din
    );
endinterface

// File: rtl/spraid_host_queue.sv
// rtl/spraid_host_queue.sv - host command FIFO feeding one RAID operation at a time
module spraid_host_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    spraid_host_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      timeout_flag,
    input  logic                      timeout_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;
    state_t state, state_nxt;

    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic          cur_write;
    logic          ack_seen;
    logic [TW-1:0] wait_cnt;
    logic          in_wait, op_done, op_timeout;

    assign level         = count;
    assign bus.cmd_ready = (count < (AW+1)'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;

    assign bus.raid_read  = (state == ISSUE) && !cur_write;
    assign bus.raid_write = (state == ISSUE) && cur_write;
    assign bus.rsp_valid  = (state == RESP);

    // A controller that never raises busy is treated as done after two quiet ack cycles.
    assign in_wait    = (state == WAIT_ACK) || (state == WAIT_DONE);
    assign op_done    = ((state == WAIT_ACK) && !bus.raid_busy && ack_seen) ||
                        ((state == WAIT_DONE) && !bus.raid_busy);
    assign op_timeout = in_wait && !op_done && (wait_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && !bus.raid_busy) begin
                    state_nxt = ISSUE;
                    pop       = 1'b1;
                end
            end
            ISSUE: state_nxt = WAIT_ACK;
            WAIT_ACK, WAIT_DONE: begin
                if ((state == WAIT_ACK) && bus.raid_busy)
                    state_nxt = WAIT_DONE;
                if (op_done || op_timeout)
                    state_nxt = cur_write ? IDLE : RESP;
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            cur_write     <= 1'b0;
            bus.raid_addr <= '0;
            bus.raid_din  <= '0;
            ack_seen      <= 1'b0;
            wait_cnt      <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {cur_write, bus.raid_addr, bus.raid_din} <= mem[rd_ptr];
            end
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);

            if (state == ISSUE) begin
                ack_seen <= 1'b0;
                wait_cnt <= '0;
            end else if (in_wait) begin
                ack_seen <= 1'b1;
                wait_cnt <= wait_cnt + TW'(1);
            end

            // Response fields only change when a read finishes, so they hold through RESP.
            if (in_wait && !cur_write) begin
                if (op_done) begin
                    bus.rsp_rdata <= bus.raid_dout;
                    bus.rsp_err   <= bus.raid_err;
                end else if (op_timeout) begin
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b1;
                end
            end

            if (op_timeout)
                timeout_flag <= 1'b1;
            else if (timeout_clr)
                timeout_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spraid_host_queue.sv
// tb/tb_spraid_host_queue.sv - self-checking bench for spraid_host_queue
module tb_spraid_host_queue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic                   timeout_flag;
    logic                   timeout_clr = 1'b0;

    spraid_host_queue_if bus();

    spraid_host_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(rst_n), .bus(bus.slave),
        .level(level), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          busy;
        logic [31:0] dout;
        logic        err;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_flag;
    } vec_t;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } cmd_t;
    typedef struct { logic [31:0] d; logic e; } rsp_t;

    vec_t vecs[7];
    cmd_t model_q[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_cmd_ready"}, bus.cmd_ready, 1);
        check({p, "_level"}, level, 0);
        check({p, "_rsp_valid"}, bus.rsp_valid, 0);
        check({p, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({p, "_rsp_err"}, bus.rsp_err, 0);
        check({p, "_raid_read"}, bus.raid_read, 0);
        check({p, "_raid_write"}, bus.raid_write, 0);
        check({p, "_raid_addr"}, bus.raid_addr, 0);
        check({p, "_raid_din"}, bus.raid_din, 0);
        check({p, "_timeout_flag"}, timeout_flag, 0);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
        for (int c = 0; c < 100; c++) begin
            if (bus.cmd_ready) begin
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        fail("push_accept", "cmd_ready never seen within 100 cycles");
    endtask

    task automatic wait_strobe(output logic got, input int limit);
        got = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (bus.raid_read || bus.raid_write) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic        seen;
        logic [31:0] got_d;
        logic        got_e;
        int          extra, unstable;
        string       p;
        p = $sformatf("vec%0d", idx);
        bus.raid_busy = 1'b0; bus.raid_dout = v.dout; bus.raid_err = v.err; bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = v.w; bus.cmd_addr = v.addr; bus.cmd_wdata = v.wdata;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({p, "_level_pushed"}, level, 1);
        check({p, "_no_early_strobe"}, bus.raid_read | bus.raid_write, 0);
        @(negedge clk);
        check({p, "_read_strobe"}, bus.raid_read, !v.w);
        check({p, "_write_strobe"}, bus.raid_write, v.w);
        check({p, "_addr"}, bus.raid_addr, v.addr);
        check({p, "_din"}, bus.raid_din, v.wdata);
        check({p, "_level_popped"}, level, 0);
        bus.raid_busy = (v.busy > 0);
        seen = 1'b0; got_d = '0; got_e = 1'b0; extra = 0; unstable = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && !seen) begin
                seen = 1'b1; got_d = bus.rsp_rdata; got_e = bus.rsp_err;
            end
            if (bus.raid_read || bus.raid_write) extra++;
            if (bus.raid_addr !== v.addr || bus.raid_din !== v.wdata) unstable++;
            if (c + 1 >= v.busy) bus.raid_busy = 1'b0;
        end
        check({p, "_rsp_seen"}, seen, v.exp_valid);
        if (seen) begin
            check({p, "_rsp_rdata"}, got_d, v.exp_rdata);
            check({p, "_rsp_err"}, got_e, v.exp_err);
        end
        check({p, "_extra_strobes"}, extra, 0);
        check({p, "_addr_stable"}, unstable, 0);
        check({p, "_timeout_flag"}, timeout_flag, v.exp_flag);
        timeout_clr = 1'b1;
        @(negedge clk);
        timeout_clr = 1'b0;
        check({p, "_flag_cleared"}, timeout_flag, 0);
    endtask

    task automatic random_phase(input int cycles);
        cmd_t pend_cmd, cur;
        rsp_t r;
        logic pend, acc;
        int   busy_left;
        pend = 1'b0; busy_left = 0;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; bus.raid_busy = 1'b0;
        for (int c = 0; c < cycles + 200; c++) begin
            @(negedge clk);
            acc = pend;
            if (pend) begin
                model_q.push_back(pend_cmd);
                pend = 1'b0;
            end
            if (bus.raid_read || bus.raid_write) begin
                if (model_q.size() == 0) begin
                    fail("rand_strobe", "strobe with no queued command");
                end else begin
                    cur = model_q.pop_front();
                    check("rand_strobe_kind", bus.raid_write, cur.w);
                    check("rand_addr", bus.raid_addr, cur.a);
                    check("rand_din", bus.raid_din, cur.d);
                end
                check("rand_no_rsp_pending", exp_rsp.size(), 0);
                busy_left = $urandom_range(0, 6);
                bus.raid_busy = (busy_left > 0);
                bus.raid_dout = $urandom;
                bus.raid_err  = 1'($urandom_range(0, 1));
                if (bus.raid_read) begin
                    r.d = bus.raid_dout; r.e = bus.raid_err;
                    exp_rsp.push_back(r);
                end
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.raid_busy = 1'b0;
            end
            check("rand_level", level, model_q.size());
            check("rand_flag", timeout_flag, 0);
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    fail("rand_rsp", "rsp_valid with no outstanding read");
                end else begin
                    check("rand_rdata", bus.rsp_rdata, exp_rsp[0].d);
                    check("rand_rerr", bus.rsp_err, exp_rsp[0].e);
                end
            end
            bus.rsp_ready = 1'($urandom_range(0, 1));
            if (bus.rsp_valid && bus.rsp_ready && exp_rsp.size() > 0) r = exp_rsp.pop_front();
            if (acc || !bus.cmd_valid) begin
                bus.cmd_valid = (c < cycles) && ($urandom_range(0, 9) < 5);
                bus.cmd_write = 1'($urandom_range(0, 1));
                bus.cmd_addr  = $urandom;
                bus.cmd_wdata = $urandom;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                pend = 1'b1;
                pend_cmd.w = bus.cmd_write; pend_cmd.a = bus.cmd_addr; pend_cmd.d = bus.cmd_wdata;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        check("rand_drained_cmds", model_q.size(), 0);
        check("rand_drained_rsps", exp_rsp.size(), 0);
    endtask

    initial begin
        logic got;
        int   n, nstrobe;
        logic pushed5;

        vecs[0] = '{1'b0, 32'h10,   32'h0,        5,  32'hA5,       1'b0, 1'b1, 32'hA5,   1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h20,   32'hDEADBEEF, 3,  32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h1234, 32'h0,        0,  32'h5A5A,     1'b1, 1'b1, 32'h5A5A, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h30,   32'h13579BDF, 0,  32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h40,   32'h0,        40, 32'h77,       1'b0, 1'b1, 32'h0,    1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h44,   32'h2468ACE0, 40, 32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'h48,   32'h0,        14, 32'hCAFE,     1'b0, 1'b1, 32'hCAFE, 1'b0, 1'b0};

        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0; bus.raid_dout = '0; bus.raid_busy = 1'b0; bus.raid_err = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Fill the FIFO while the controller is busy, then drain in order.
        bus.raid_busy = 1'b1;
        for (int k = 0; k < 4; k++) push_cmd(1'b1, 32'h100 + k, 32'hF00 + k);
        check("fill_ready_low", bus.cmd_ready, 0);
        check("fill_level", level, 4);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h104; bus.cmd_wdata = 32'hF04;
        repeat (3) @(negedge clk);
        check("fill_hold_ready", bus.cmd_ready, 0);
        check("fill_hold_level", level, 4);
        bus.raid_busy = 1'b0;
        nstrobe = 0; pushed5 = 1'b0;
        for (int c = 0; c < 60 && nstrobe < 5; c++) begin
            if (!pushed5 && bus.cmd_ready) begin
                pushed5 = 1'b1;
                check("fill_5th_level", level, 3);
            end
            @(negedge clk);
            if (pushed5) bus.cmd_valid = 1'b0;
            if (bus.raid_write) begin
                check("fill_order_addr", bus.raid_addr, 32'h100 + nstrobe);
                check("fill_order_din", bus.raid_din, 32'hF00 + nstrobe);
                nstrobe++;
            end
        end
        bus.cmd_valid = 1'b0;
        check("fill_strobes", nstrobe, 5);
        repeat (5) @(negedge clk);

        // Response backpressure holds the FSM in RESP.
        bus.rsp_ready = 1'b0; bus.raid_busy = 1'b0; bus.raid_dout = 32'h1234ABCD; bus.raid_err = 1'b0;
        push_cmd(1'b0, 32'h300, 32'h0);
        wait_strobe(got, 10);
        check("bp_read_strobe", got && bus.raid_read, 1);
        push_cmd(1'b1, 32'h304, 32'h99);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (bus.rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        check("bp_rsp_valid", got, 1);
        bus.raid_dout = 32'hBAD0BAD0;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid_held", bus.rsp_valid, 1);
            check("bp_rdata_stable", bus.rsp_rdata, 32'h1234ABCD);
            check("bp_no_strobe", bus.raid_read | bus.raid_write, 0);
            check("bp_level", level, 1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_dropped", bus.rsp_valid, 0);
        wait_strobe(got, 10);
        check("bp_next_write", got && bus.raid_write, 1);
        check("bp_next_addr", bus.raid_addr, 32'h304);
        repeat (5) @(negedge clk);

        // Timeout while timeout_clr is held: set wins on the timeout edge.
        timeout_clr = 1'b1;
        push_cmd(1'b0, 32'h600, 32'h0);
        wait_strobe(got, 10);
        check("to_read_strobe", got && bus.raid_read, 1);
        bus.raid_busy = 1'b1;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                n = c;
                break;
            end
        end
        check("to_latency", n, TIMEOUT + 1);
        check("to_flag_set_wins", timeout_flag, 1);
        check("to_rsp_err", bus.rsp_err, 1);
        check("to_rsp_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        check("to_flag_cleared", timeout_flag, 0);
        timeout_clr = 1'b0;
        bus.raid_busy = 1'b0;
        repeat (3) @(negedge clk);

        random_phase(600);
        repeat (5) @(negedge clk);

        // Reset mid-WAIT_DONE with three commands queued behind.
        bus.raid_busy = 1'b0; bus.rsp_ready = 1'b1;
        push_cmd(1'b0, 32'h500, 32'h0);
        wait_strobe(got, 10);
        check("rst_read_strobe", got && bus.raid_read, 1);
        bus.raid_busy = 1'b1;
        for (int k = 0; k < 3; k++) push_cmd(1'b1, 32'h510 + k, 32'h7 + k);
        check("rst_level_before", level, 3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.raid_busy = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.raid_read || bus.raid_write) n++;
        end
        check("rst_no_strobe", n, 0);
        check("rst_level_after", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
